// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Package     : y86_pkg
// Description : Shared Y86 icodes, status codes, register encodings and
//               pipeline-bubble helpers for the hazard/forwarding control.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] c_icode_halt  = 4'h0;
    localparam logic [3:0] c_icode_nop   = 4'h1;
    localparam logic [3:0] c_icode_cmov  = 4'h2;
    localparam logic [3:0] c_icode_irmov = 4'h3;
    localparam logic [3:0] c_icode_rmmov = 4'h4;
    localparam logic [3:0] c_icode_mrmov = 4'h5;
    localparam logic [3:0] c_icode_opq   = 4'h6;
    localparam logic [3:0] c_icode_jxx   = 4'h7;
    localparam logic [3:0] c_icode_call  = 4'h8;
    localparam logic [3:0] c_icode_ret   = 4'h9;
    localparam logic [3:0] c_icode_push  = 4'hA;
    localparam logic [3:0] c_icode_pop   = 4'hB;

    localparam logic [2:0] c_stat_aok = 3'd1;
    localparam logic [2:0] c_stat_hlt = 3'd2;
    localparam logic [2:0] c_stat_adr = 3'd3;
    localparam logic [2:0] c_stat_ins = 3'd4;

    localparam logic [3:0] c_rnone = 4'hF;

    // Control header of a bubble: {icode, rA, rB, stat}; data fields are zero.
    function automatic logic [14:0] bubble_hdr(input logic [3:0] rnone);
        return {c_icode_nop, rnone, rnone, c_stat_aok};
    endfunction

    function automatic logic is_load_icode(input logic [3:0] icode);
        return (icode == c_icode_mrmov) || (icode == c_icode_pop);
    endfunction

endpackage : y86_pkg
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Pipeline register with stall (hold) and bubble (load NOP);
//               bubble wins over stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            r_q <= BUBBLE;
        end else if (!stall) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : pipe_reg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : E->M and M->W pipeline registers feeding forwarding/writeback,
//               F/D/E stall and bubble generation, and the halt state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int         N     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_srcA,
    input  logic [3:0]   d_srcB,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_rA,
    input  logic [3:0]   e_rB,
    input  logic [N-1:0] e_valE,
    input  logic         e_cnd,
    input  logic [2:0]   e_stat,
    input  logic [N-1:0] m_valM_in,
    input  logic         m_dmem_err,
    output logic [3:0]   m_icode,
    output logic [3:0]   m_rA,
    output logic [3:0]   m_rB,
    output logic [N-1:0] m_valE,
    output logic [N-1:0] m_valM,
    output logic [3:0]   w_icode,
    output logic [3:0]   w_rA,
    output logic [3:0]   w_rB,
    output logic [N-1:0] w_valE,
    output logic [N-1:0] w_valM,
    output logic [2:0]   w_stat,
    output logic         f_stall,
    output logic         d_stall,
    output logic         d_bubble,
    output logic         e_bubble,
    output logic         halted
);

    localparam int c_m_width = 15 + N;
    localparam int c_w_width = 15 + 2 * N;

    localparam logic [c_m_width-1:0] c_m_bubble = {bubble_hdr(RNONE), {N{1'b0}}};
    localparam logic [c_w_width-1:0] c_w_bubble = {bubble_hdr(RNONE), {(2 * N){1'b0}}};

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_drain  = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    logic [1:0]           r_state;
    logic [c_m_width-1:0] w_m_d;
    logic [c_m_width-1:0] w_m_q;
    logic [c_w_width-1:0] w_w_d;
    logic [c_w_width-1:0] w_w_q;
    logic [3:0]           w_e_rb_eff;
    logic [2:0]           w_m_stat_reg;
    logic [2:0]           w_m_stat;
    logic                 w_m_bubble;
    logic                 w_w_stall;
    logic                 w_load_use;
    logic                 w_mispred;
    logic                 w_ret_in;

    // A cmov whose condition failed must not write its destination.
    assign w_e_rb_eff = (e_icode == c_icode_cmov && !e_cnd) ? RNONE : e_rB;
    assign w_m_d      = {e_icode, e_rA, w_e_rb_eff, e_stat, e_valE};

    pipe_reg #(
        .WIDTH  (c_m_width),
        .BUBBLE (c_m_bubble)
    ) u_m_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (1'b0),
        .bubble (w_m_bubble),
        .d      (w_m_d),
        .q      (w_m_q)
    );

    assign {m_icode, m_rA, m_rB, w_m_stat_reg, m_valE} = w_m_q;
    assign m_valM   = m_valM_in;
    assign w_m_stat = m_dmem_err ? c_stat_adr : w_m_stat_reg;

    assign w_w_d = {m_icode, m_rA, m_rB, w_m_stat, m_valE, m_valM_in};

    pipe_reg #(
        .WIDTH  (c_w_width),
        .BUBBLE (c_w_bubble)
    ) u_w_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (w_w_stall),
        .bubble (1'b0),
        .d      (w_w_d),
        .q      (w_w_q)
    );

    assign {w_icode, w_rA, w_rB, w_stat, w_valE, w_valM} = w_w_q;

    assign w_load_use = is_load_icode(e_icode) && (e_rA != RNONE) &&
                        ((e_rA == d_srcA) || (e_rA == d_srcB));
    assign w_mispred  = (e_icode == c_icode_jxx) && !e_cnd;
    assign w_ret_in   = (d_icode == c_icode_ret) || (e_icode == c_icode_ret) ||
                        (m_icode == c_icode_ret);
    assign w_m_bubble = (w_m_stat != c_stat_aok) || (w_stat != c_stat_aok);
    assign w_w_stall  = (w_stat != c_stat_aok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_run;
        end else begin
            case (r_state)
                c_st_run:    if (w_m_stat != c_stat_aok) r_state <= c_st_drain;
                c_st_drain:  if (w_stat != c_stat_aok) r_state <= c_st_halted;
                c_st_halted: r_state <= c_st_halted;
                default:     r_state <= c_st_run;
            endcase
        end
    end

    assign halted = (r_state == c_st_halted);

    // Load-use takes priority over ret for D: stall rather than bubble.
    always_comb begin
        f_stall  = w_load_use | w_ret_in;
        d_stall  = w_load_use;
        d_bubble = w_mispred | (w_ret_in & ~w_load_use);
        e_bubble = w_mispred | w_load_use;
        if (halted) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
        end
    end

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Scoreboard bench for pipe_hazard_ctrl using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   d_icode, d_srcA, d_srcB;
    logic [3:0]   e_icode, e_rA, e_rB;
    logic [N-1:0] e_valE;
    logic         e_cnd;
    logic [2:0]   e_stat;
    logic [N-1:0] m_valM_in;
    logic         m_dmem_err;
    logic [3:0]   m_icode, m_rA, m_rB;
    logic [N-1:0] m_valE, m_valM;
    logic [3:0]   w_icode, w_rA, w_rB;
    logic [N-1:0] w_valE, w_valM;
    logic [2:0]   w_stat;
    logic         f_stall, d_stall, d_bubble, e_bubble, halted;

    pipe_hazard_ctrl #(.N(N), .RNONE(4'hF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_icode    (d_icode),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .e_icode    (e_icode),
        .e_rA       (e_rA),
        .e_rB       (e_rB),
        .e_valE     (e_valE),
        .e_cnd      (e_cnd),
        .e_stat     (e_stat),
        .m_valM_in  (m_valM_in),
        .m_dmem_err (m_dmem_err),
        .m_icode    (m_icode),
        .m_rA       (m_rA),
        .m_rB       (m_rB),
        .m_valE     (m_valE),
        .m_valM     (m_valM),
        .w_icode    (w_icode),
        .w_rA       (w_rA),
        .w_rB       (w_rB),
        .w_valE     (w_valE),
        .w_valM     (w_valM),
        .w_stat     (w_stat),
        .f_stall    (f_stall),
        .d_stall    (d_stall),
        .d_bubble   (d_bubble),
        .e_bubble   (e_bubble),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Selectors: 0 ctrl {f_stall,d_stall,d_bubble,e_bubble,halted}, 1 {m_icode,m_rA,m_rB},
    // 2 m_valE, 3 {w_icode,w_rA,w_rB,w_stat}, 4 w_valE, 5 w_valM, 6 m_valM
    typedef struct {
        int           cyc;
        string        name;
        int           sel;
        logic [127:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] actual(input int sel);
        case (sel)
            0:       return 128'({f_stall, d_stall, d_bubble, e_bubble, halted});
            1:       return 128'({m_icode, m_rA, m_rB});
            2:       return 128'(m_valE);
            3:       return 128'({w_icode, w_rA, w_rB, w_stat});
            4:       return 128'(w_valE);
            5:       return 128'(w_valM);
            default: return 128'(m_valM);
        endcase
    endfunction

    task automatic push_exp(input int dly, input string name, input int sel,
                            input logic [127:0] v);
        exp_t e;
        e.cyc  = cyc + dly;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Monitor: checks every entry due in the current cycle at mid-cycle.
    always @(negedge clk) begin
        int           i;
        logic [127:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                n_vec++;
                act = actual(sb[i].sel);
                if (act !== sb[i].exp) begin
                    n_miss++;
                    $display("FAIL %s: got %0h expected %0h", sb[i].name, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s: got no check expected cycle %0d", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic idle();
        d_icode    = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        e_icode    = 4'h1; e_rA   = 4'hF; e_rB   = 4'hF;
        e_valE     = '0;   e_cnd  = 1'b0; e_stat = 3'd1;
        m_valM_in  = '0;   m_dmem_err = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        step();
        push_exp(0, "rst_ctrl", 0, 5'b00000);
        push_exp(0, "rst_m",    1, 12'h1FF);
        push_exp(0, "rst_w",    3, {4'h1, 4'hF, 4'hF, 3'd1});
        rst_n = 1'b1;

        // Load-use through srcB, then cleared
        step(); idle(); e_icode = 4'h5; e_rA = 4'h3; d_srcB = 4'h3;
        push_exp(0, "lu_mrmov", 0, 5'b11010);
        step(); idle();
        push_exp(0, "lu_clear", 0, 5'b00000);
        // RNONE destination never matches an unused source
        step(); idle(); e_icode = 4'hB; e_rA = 4'hF; d_srcA = 4'hF;
        push_exp(0, "lu_rnone", 0, 5'b00000);
        step(); idle(); e_icode = 4'hB; e_rA = 4'h4; d_srcA = 4'h4;
        push_exp(0, "lu_popq", 0, 5'b11010);

        // Mispredict
        step(); idle(); e_icode = 4'h7; e_cnd = 1'b0;
        push_exp(0, "mispred", 0, 5'b00110);
        step(); idle(); e_icode = 4'h7; e_cnd = 1'b1;
        push_exp(0, "jxx_taken", 0, 5'b00000);

        // ret walking D -> E -> M
        step(); idle(); d_icode = 4'h9;
        push_exp(0, "ret_d", 0, 5'b10100);
        step(); idle(); e_icode = 4'h9;
        push_exp(0, "ret_e", 0, 5'b10100);
        step(); idle();
        push_exp(0, "ret_m", 0, 5'b10100);
        step(); idle();
        push_exp(0, "ret_gone", 0, 5'b00000);

        // Coincident hazards
        step(); idle(); d_icode = 4'h9; e_icode = 4'h5; e_rA = 4'h2; d_srcA = 4'h2;
        push_exp(0, "lu_ret", 0, 5'b11010);
        step(); idle(); d_icode = 4'h9; e_icode = 4'h7; e_cnd = 1'b0;
        push_exp(0, "misp_ret", 0, 5'b10110);

        // cmov destination squash
        step(); idle(); e_icode = 4'h2; e_rA = 4'h1; e_rB = 4'h5; e_cnd = 1'b0;
        push_exp(1, "cmov_nt", 1, 12'h21F);
        step(); idle(); e_icode = 4'h2; e_rA = 4'h1; e_rB = 4'h5; e_cnd = 1'b1;
        push_exp(1, "cmov_t", 1, 12'h215);

        // Forward timing E -> M -> W, plus valM pass-through
        step(); idle(); e_icode = 4'h6; e_rB = 4'h2; e_valE = 64'h55;
        push_exp(1, "fwd_m_regs", 1, 12'h6F2);
        push_exp(1, "fwd_m_valE", 2, 64'h55);
        push_exp(2, "fwd_w_regs", 3, {4'h6, 4'hF, 4'h2, 3'd1});
        push_exp(2, "fwd_w_valE", 4, 64'h55);
        step(); idle(); m_valM_in = 64'h1234;
        push_exp(0, "m_valM_pass", 6, 64'h1234);
        push_exp(1, "w_valM", 5, 64'h1234);
        step(); idle();

        // Exception: rmmovq faults in M
        step(); idle(); e_icode = 4'h4; e_rA = 4'h1; e_rB = 4'h2; e_valE = 64'h100;
        step(); idle(); m_dmem_err = 1'b1;
        push_exp(0, "exc_m_rmmov", 1, 12'h412);
        push_exp(0, "exc_ctrl0", 0, 5'b00000);
        push_exp(1, "exc_m_bubble", 1, 12'h1FF);
        push_exp(1, "exc_w_adr", 3, {4'h4, 4'h1, 4'h2, 3'd3});
        push_exp(1, "exc_drain", 0, 5'b00000);
        push_exp(2, "exc_halted", 0, 5'b11011);
        step(); idle(); e_icode = 4'h6; e_rB = 4'h7; e_valE = 64'h99;
        push_exp(2, "exc_w_hold", 3, {4'h4, 4'h1, 4'h2, 3'd3});
        push_exp(2, "exc_w_valE", 4, 64'h100);
        push_exp(2, "exc_m_squash", 1, 12'h1FF);
        push_exp(3, "exc_sticky", 0, 5'b11011);
        step(); step(); step();

        // Reset out of HALTED
        idle(); rst_n = 1'b0;
        push_exp(1, "rst_halt_ctrl", 0, 5'b00000);
        push_exp(1, "rst_halt_w", 3, {4'h1, 4'hF, 4'hF, 3'd1});
        step(); rst_n = 1'b1;
        step(); idle(); e_icode = 4'h5; e_rA = 4'h6; d_srcA = 4'h6;
        push_exp(0, "lu_after_rst", 0, 5'b11010);
        step(); idle();

        repeat (4) step();
        while (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got unchecked expected cycle %0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
